// File: rtl/ni_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : ni_packetizer
//  Description : Injection side of a network interface. Turns a packet request
//                plus a stream of 28-bit payload words into header / body /
//                tail flits (even parity in bit 0) for a router Local port.
//                Flits are paced by the router's CTS, and payload is staged
//                in a small FIFO so the PE can run ahead of the link.
//  Ports       : clk, rst (async, active-low)
//                cur_addr            - own node address (header source field)
//                pkt_req/dst/len     - packet request, held until pkt_ack
//                pkt_ack/pkt_err     - 1-cycle accept/reject pulse
//                pl_valid/data/ready - payload word stream into the FIFO
//                tx_data/tx_drts     - registered flit and its valid strobe
//                tx_cts              - router input FIFO ready
//                busy, pkt_sent      - activity flag, tail-flit pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module ni_packetizer #(
    parameter int DATA_WIDTH    = 32,
    parameter int AXIS          = 4,
    parameter int PL_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXIS-1:0]       cur_addr,
    input  logic                  pkt_req,
    input  logic [AXIS-1:0]       pkt_dst,
    input  logic [11:0]           pkt_len,
    output logic                  pkt_ack,
    output logic                  pkt_err,
    input  logic                  pl_valid,
    input  logic [DATA_WIDTH-5:0] pl_data,
    output logic                  pl_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_drts,
    input  logic                  tx_cts,
    output logic                  busy,
    output logic                  pkt_sent
);

    localparam int c_aw = $clog2(PL_FIFO_DEPTH);
    localparam int c_pw = DATA_WIDTH - 4;

    localparam logic [2:0]    c_type_hdr  = 3'b001;
    localparam logic [2:0]    c_type_body = 3'b010;
    localparam logic [2:0]    c_type_tail = 3'b100;
    localparam logic [c_aw:0] c_ptr_one   = {{c_aw{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_BODY   = 2'd2,
        ST_TAIL   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Payload FIFO: pointers carry one extra wrap bit to tell full from empty.
    logic [c_pw-1:0] r_mem [PL_FIFO_DEPTH];
    logic [c_aw:0]   r_wptr;
    logic [c_aw:0]   r_rptr;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [c_pw-1:0] w_head;

    // Held low through reset and the first edge after it so that pl_ready
    // stays deasserted while rst is active.
    logic            r_run;

    logic                  r_pkt_ack;
    logic                  r_pkt_err;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_drts;
    logic                  r_pkt_sent;
    logic [7:0]            r_pkt_id;
    logic [AXIS-1:0]       r_dst;
    logic [11:0]           r_remaining;

    logic                  w_accept;
    logic                  w_len_bad;
    logic                  w_send;
    logic [DATA_WIDTH-1:0] w_flit_np;
    logic [DATA_WIDTH-1:0] w_flit;

    assign w_full  = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                     (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_head  = r_mem[r_rptr[c_aw-1:0]];

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign pl_ready = r_run && (!w_full || w_pop);
    assign w_push   = pl_valid && pl_ready;

    assign w_len_bad = (pkt_len == 12'd0) || (pkt_len == 12'hFFF);

    // Next-state and send decision
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_send      = 1'b0;
        w_pop       = 1'b0;
        w_flit_np   = '0;
        case (r_state)
            ST_IDLE: begin
                // r_pkt_ack blocks a second accept while the PE still holds
                // pkt_req during the ack cycle.
                if (pkt_req && !r_pkt_ack) begin
                    w_accept = 1'b1;
                    if (!w_len_bad) begin
                        w_state_nxt = ST_HEADER;
                    end
                end
            end
            ST_HEADER: begin
                if (tx_cts) begin
                    w_send      = 1'b1;
                    w_flit_np   = {c_type_hdr, r_remaining + 12'd1, r_dst,
                                   cur_addr, r_pkt_id, 1'b0};
                    w_state_nxt = (r_remaining > 12'd1) ? ST_BODY : ST_TAIL;
                end
            end
            ST_BODY: begin
                if (tx_cts && !w_empty) begin
                    w_send    = 1'b1;
                    w_pop     = 1'b1;
                    w_flit_np = {c_type_body, w_head, 1'b0};
                    if (r_remaining == 12'd2) begin
                        w_state_nxt = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                if (tx_cts && !w_empty) begin
                    w_send      = 1'b1;
                    w_pop       = 1'b1;
                    w_flit_np   = {c_type_tail, w_head, 1'b0};
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Even parity: bit 0 makes the XOR of the whole flit zero.
    assign w_flit = {w_flit_np[DATA_WIDTH-1:1], ^w_flit_np[DATA_WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run       <= 1'b0;
            r_pkt_ack   <= 1'b0;
            r_pkt_err   <= 1'b0;
            r_tx_data   <= '0;
            r_tx_drts   <= 1'b0;
            r_pkt_sent  <= 1'b0;
            r_pkt_id    <= 8'd0;
            r_dst       <= '0;
            r_remaining <= 12'd0;
            r_wptr      <= '0;
            r_rptr      <= '0;
        end else begin
            r_run      <= 1'b1;
            r_pkt_ack  <= w_accept;
            r_pkt_err  <= w_accept && w_len_bad;
            r_tx_drts  <= w_send;
            r_pkt_sent <= w_send && (r_state == ST_TAIL);
            if (w_send) begin
                r_tx_data <= w_flit;
            end
            if (w_accept && !w_len_bad) begin
                r_dst       <= pkt_dst;
                r_remaining <= pkt_len;
            end else if (w_send && (r_state == ST_BODY)) begin
                r_remaining <= r_remaining - 12'd1;
            end
            if (w_send && (r_state == ST_TAIL)) begin
                r_pkt_id <= r_pkt_id + 8'd1;
            end
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[c_aw-1:0]] <= pl_data;
        end
    end

    assign pkt_ack  = r_pkt_ack;
    assign pkt_err  = r_pkt_err;
    assign tx_data  = r_tx_data;
    assign tx_drts  = r_tx_drts;
    assign pkt_sent = r_pkt_sent;
    assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ni_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ni_packetizer
//  Description : Directed self-checking bench for ni_packetizer. A feeder
//                process streams payload words from feed_q; a monitor logs
//                every flit with its cycle stamp and pkt_sent flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ni_packetizer;

    logic        clk;
    logic        rst;
    logic [3:0]  cur_addr;
    logic        pkt_req;
    logic [3:0]  pkt_dst;
    logic [11:0] pkt_len;
    logic        pkt_ack;
    logic        pkt_err;
    logic        pl_valid;
    logic [27:0] pl_data;
    logic        pl_ready;
    logic [31:0] tx_data;
    logic        tx_drts;
    logic        tx_cts;
    logic        busy;
    logic        pkt_sent;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [27:0] feed_q [$];
    logic        feed_acc = 1'b0;
    logic [31:0] flit_q [$];
    logic        sent_q [$];
    int          cyc_q  [$];
    logic [31:0] exp_q  [$];

    ni_packetizer #(
        .DATA_WIDTH    (32),
        .AXIS          (4),
        .PL_FIFO_DEPTH (4)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .cur_addr (cur_addr),
        .pkt_req  (pkt_req),
        .pkt_dst  (pkt_dst),
        .pkt_len  (pkt_len),
        .pkt_ack  (pkt_ack),
        .pkt_err  (pkt_err),
        .pl_valid (pl_valid),
        .pl_data  (pl_data),
        .pl_ready (pl_ready),
        .tx_data  (tx_data),
        .tx_drts  (tx_drts),
        .tx_cts   (tx_cts),
        .busy     (busy),
        .pkt_sent (pkt_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Feeder: present the head of feed_q, note acceptance just before the edge
    always @(negedge clk) begin
        #2;
        if (feed_q.size() > 0) begin
            pl_valid = 1'b1;
            pl_data  = feed_q[0];
        end else begin
            pl_valid = 1'b0;
        end
        #1;
        feed_acc = pl_valid && pl_ready;
    end

    always @(posedge clk) begin
        if (feed_acc) begin
            void'(feed_q.pop_front());
            feed_acc = 1'b0;
        end
    end

    // Monitor
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (tx_drts) begin
            flit_q.push_back(tx_data);
            sent_q.push_back(pkt_sent);
            cyc_q.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] par(input logic [31:0] f);
        return {f[31:1], ^f[31:1]};
    endfunction

    function automatic logic [31:0] hdr(input logic [11:0] len, input logic [3:0] dst,
                                        input logic [7:0] id);
        return par({3'b001, len + 12'd1, dst, 4'h1, id, 1'b0});
    endfunction

    function automatic logic [31:0] pay(input logic [2:0] typ, input logic [27:0] w);
        return par({typ, w, 1'b0});
    endfunction

    task automatic clear_logs();
        flit_q.delete();
        sent_q.delete();
        cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic send_pkt(input logic [3:0] dst, input logic [11:0] len,
                            input logic exp_err, input string tag);
        logic got;
        got = 1'b0;
        @(negedge clk);
        pkt_req = 1'b1;
        pkt_dst = dst;
        pkt_len = len;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (pkt_ack) begin
                got = 1'b1;
                check({tag, "_err"}, {31'd0, pkt_err}, {31'd0, exp_err});
            end
        end
        check({tag, "_ack"}, {31'd0, got}, 32'd1);
        @(negedge clk);
        pkt_req = 1'b0;
    endtask

    task automatic wait_sent(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            if (pkt_sent) got = 1'b1;
        end
        check({tag, "_sent"}, {31'd0, got}, 32'd1);
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, 32'(flit_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < flit_q.size()) begin
                check($sformatf("%s_flit%0d", tag, i), flit_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        logic [7:0] exp_id;
        int         gap_flits;
        int         gap_acks;
        logic       got;

        rst      = 1'b0;
        cur_addr = 4'h1;
        pkt_req  = 1'b0;
        pkt_dst  = 4'h0;
        pkt_len  = 12'd0;
        tx_cts   = 1'b1;

        // T1: reset with a word pending; it becomes T2's payload after release
        feed_q.push_back(28'h0ABCDEF);
        tick(); tick(); tick();
        check("t1_pl_ready_rst", {31'd0, pl_ready}, 32'd0);
        check("t1_tx_data",      tx_data, 32'd0);
        check("t1_tx_drts",      {31'd0, tx_drts}, 32'd0);
        check("t1_ack_err",      {30'd0, pkt_ack, pkt_err}, 32'd0);
        check("t1_busy_sent",    {30'd0, busy, pkt_sent}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("t1_pl_ready_rel", {31'd0, pl_ready}, 32'd1);

        // T2: minimum packet
        clear_logs();
        send_pkt(4'h3, 12'd1, 1'b0, "t2");
        wait_sent("t2");
        exp_q.push_back(32'h2004_6201);
        exp_q.push_back(32'h8157_9BDE);
        check_stream("t2");
        if (sent_q.size() == 2) begin
            check("t2_sent_hdr",  {31'd0, sent_q[0]}, 32'd0);
            check("t2_sent_tail", {31'd0, sent_q[1]}, 32'd1);
        end
        tick();
        check("t2_idle", {31'd0, busy}, 32'd0);

        // T3: prefilled FIFO, len=5 streams back-to-back (id 1)
        clear_logs();
        for (int i = 0; i < 5; i++) feed_q.push_back(28'h1000001 + 28'(i * 28'h0111111));
        repeat (8) tick();
        check("t3_prefill", 32'(feed_q.size()), 32'd1);
        send_pkt(4'h7, 12'd5, 1'b0, "t3");
        wait_sent("t3");
        exp_q.push_back(hdr(12'd5, 4'h7, 8'd1));
        for (int i = 0; i < 4; i++) exp_q.push_back(pay(3'b010, 28'h1000001 + 28'(i * 28'h0111111)));
        exp_q.push_back(pay(3'b100, 28'h1000001 + 28'(4 * 28'h0111111)));
        check_stream("t3");
        if (cyc_q.size() == 6) check("t3_back_to_back", 32'(cyc_q[5] - cyc_q[0]), 32'd5);

        // T4: backpressure after the 2nd flit, new request ignored while busy (id 2)
        clear_logs();
        for (int i = 0; i < 4; i++) feed_q.push_back(28'hA000000 + 28'(i));
        repeat (6) tick();
        send_pkt(4'hC, 12'd4, 1'b0, "t4");
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (flit_q.size() >= 2) got = 1'b1;
            else tick();
        end
        check("t4_two_flits", {31'd0, got}, 32'd1);
        @(negedge clk);
        tx_cts    = 1'b0;
        pkt_req   = 1'b1;
        pkt_len   = 12'd1;
        gap_flits = 0;
        gap_acks  = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (tx_drts) gap_flits++;
            if (pkt_ack) gap_acks++;
        end
        @(negedge clk);
        pkt_req = 1'b0;
        tx_cts  = 1'b1;
        check("t4_gap_flits", {31'd0, gap_flits <= 1}, 32'd1);
        check("t4_no_ack_busy", 32'(gap_acks), 32'd0);
        wait_sent("t4");
        exp_q.push_back(hdr(12'd4, 4'hC, 8'd2));
        for (int i = 0; i < 3; i++) exp_q.push_back(pay(3'b010, 28'hA000000 + 28'(i)));
        exp_q.push_back(pay(3'b100, 28'hA000003));
        check_stream("t4");

        // T5: rejected lengths
        clear_logs();
        send_pkt(4'h2, 12'd0, 1'b1, "t5_len0");
        send_pkt(4'h2, 12'hFFF, 1'b1, "t5_len4095");
        repeat (3) tick();
        check("t5_idle", {31'd0, busy}, 32'd0);
        check("t5_no_flits", 32'(flit_q.size()), 32'd0);

        // Reset mid-packet: FIFO is flushed and pkt_id restarts at 0
        clear_logs();
        @(negedge clk);
        tx_cts = 1'b0;
        for (int i = 0; i < 3; i++) feed_q.push_back(28'hDEAD000 + 28'(i));
        repeat (5) tick();
        send_pkt(4'h5, 12'd4, 1'b0, "rst_abort");
        tick();
        check("rst_abort_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        feed_q.delete();
        rst = 1'b0;
        #1;
        check("rst_abort_idle", {29'd0, busy, tx_drts, pl_ready}, 32'd0);
        @(negedge clk);
        rst    = 1'b1;
        tx_cts = 1'b1;
        tick();

        // T6: 257 single-word packets, ids 0..255 then wrap to 0
        exp_id = 8'd0;
        for (int p = 0; p < 257; p++) begin
            clear_logs();
            feed_q.push_back(28'h0F00000 + 28'(p * 3));
            send_pkt(4'(p), 12'd1, 1'b0, $sformatf("t6_p%0d", p));
            wait_sent($sformatf("t6_p%0d", p));
            exp_q.push_back(hdr(12'd1, 4'(p), exp_id));
            exp_q.push_back(pay(3'b100, 28'h0F00000 + 28'(p * 3)));
            check_stream($sformatf("t6_p%0d", p));
            exp_id = exp_id + 8'd1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
